// File: rtl/ref_row_pkg.sv
// ============================================================================
// Module      : ref_row_pkg
// Description : Shared geometry constants and state encoding for ref_row_server.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ref_row_pkg;

    localparam int PIX_W     = 8;
    localparam int ROW_PIX   = 15;
    localparam int NUM_ROWS  = 15;
    localparam int ROW_W     = PIX_W * ROW_PIX;
    localparam int COL_W     = $clog2(ROW_PIX);
    localparam int ROW_IDX_W = $clog2(NUM_ROWS);

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/row_packer.sv
// ============================================================================
// Module      : row_packer
// Description : Gathers ROW_PIX raster pixels into one packed row word and
//               pulses row_done on the edge that completes the row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_packer
    import ref_row_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix,
    output logic [ROW_W-1:0] row_word,
    output logic             row_done
);

    localparam logic [COL_W-1:0] c_last_col = COL_W'(ROW_PIX - 1);

    logic [COL_W-1:0] r_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
        end else if (clr) begin
            r_col <= '0;
        end else if (pix_valid) begin
            r_col <= (r_col == c_last_col) ? '0 : r_col + COL_W'(1);
        end
    end

    assign row_done = pix_valid && (r_col == c_last_col);

    // The last lane bypasses storage so the word is complete on the same edge.
    generate
        for (genvar c = 0; c < ROW_PIX; c++) begin : g_lane
            if (c == ROW_PIX - 1) begin : g_last
                assign row_word[c*PIX_W +: PIX_W] = pix;
            end else begin : g_store
                logic [PIX_W-1:0] r_lane;
                always_ff @(posedge clk) begin
                    if (pix_valid && (r_col == COL_W'(c))) begin
                        r_lane <= pix;
                    end
                end
                assign row_word[c*PIX_W +: PIX_W] = r_lane;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/ref_row_server.sv
// ============================================================================
// Module      : ref_row_server
// Description : Loads a raster reference block into row storage and serves
//               whole rows with one-cycle latency. Macro REF_ROW_PAD_EN clamps
//               out-of-range row reads to the last row instead of erroring.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ref_row_server
    import ref_row_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [PIX_W-1:0] wr_pixel,
    output logic             wr_ready,
    input  logic             frame_clr,
    output logic             frame_ready,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_row,
    output logic [ROW_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err
);

    localparam logic [ROW_IDX_W-1:0] c_last_row = ROW_IDX_W'(NUM_ROWS - 1);

    state_t                 r_state;
    logic [ROW_IDX_W-1:0]   r_row;
    logic                   r_wr_ready;
    logic                   r_frame_ready;
    logic [ROW_W-1:0]       r_mem [NUM_ROWS];
    logic [ROW_W-1:0]       r_rd_data;
    logic                   r_rd_valid;
    logic                   r_rd_err;

    logic                   w_accept;
    logic [ROW_W-1:0]       w_row_word;
    logic                   w_row_done;
    logic                   w_in_range;
    logic [ROW_IDX_W-1:0]   w_rd_idx;
    logic                   w_rd_err;

    assign w_accept = wr_valid && r_wr_ready && !frame_clr;

    row_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (frame_clr),
        .pix_valid (w_accept),
        .pix       (wr_pixel),
        .row_word  (w_row_word),
        .row_done  (w_row_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= LOAD;
            r_row         <= '0;
            r_wr_ready    <= 1'b1;
            r_frame_ready <= 1'b0;
        end else if (frame_clr) begin
            r_state       <= LOAD;
            r_row         <= '0;
            r_wr_ready    <= 1'b1;
            r_frame_ready <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_row_done) begin
                        if (r_row == c_last_row) begin
                            r_state       <= READY;
                            r_row         <= '0;
                            r_wr_ready    <= 1'b0;
                            r_frame_ready <= 1'b1;
                        end else begin
                            r_row <= r_row + ROW_IDX_W'(1);
                        end
                    end
                end
                READY: begin
                    r_state <= READY;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_row_done) begin
            r_mem[r_row] <= w_row_word;
        end
    end

    // Index is always clamped so the storage is never addressed out of range.
    always_comb begin
        w_in_range = (rd_row < IDX_W'(NUM_ROWS));
        w_rd_idx   = w_in_range ? rd_row[ROW_IDX_W-1:0] : c_last_row;
`ifdef REF_ROW_PAD_EN
        w_rd_err   = (r_state != READY) || frame_clr;
`else
        w_rd_err   = (r_state != READY) || frame_clr || !w_in_range;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_req;
            r_rd_err   <= rd_req && w_rd_err;
            if (rd_req) begin
                r_rd_data <= w_rd_err ? '0 : r_mem[w_rd_idx];
            end
        end
    end

    assign wr_ready    = r_wr_ready;
    assign frame_ready = r_frame_ready;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign rd_err      = r_rd_err;

endmodule

`default_nettype wire

// File: tb/tb_ref_row_server.sv
// ============================================================================
// Module      : tb_ref_row_server
// Description : Self-checking bench for ref_row_server against a flat-image
//               reference model; honours REF_ROW_PAD_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ref_row_server;
    import ref_row_pkg::*;

    localparam int FRAME_PIX = NUM_ROWS * ROW_PIX;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic [PIX_W-1:0] wr_pixel;
    logic             wr_ready;
    logic             frame_clr;
    logic             frame_ready;
    logic             rd_req;
    logic [7:0]       rd_row;
    logic [ROW_W-1:0] rd_data;
    logic             rd_valid;
    logic             rd_err;

    ref_row_server #(.IDX_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_pixel    (wr_pixel),
        .wr_ready    (wr_ready),
        .frame_clr   (frame_clr),
        .frame_ready (frame_ready),
        .rd_req      (rd_req),
        .rd_row      (rd_row),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_err      (rd_err)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [7:0]       img [FRAME_PIX];
    int               cnt;
    logic [ROW_W-1:0] exp_data;

    typedef struct {
        logic [7:0] row;
        logic       exp_err;
        logic [7:0] exp_b0;
    } rd_vec_t;

    rd_vec_t tbl [6];

    task automatic check(input string name, input logic [ROW_W-1:0] act,
                         input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] model_row(input int r);
        logic [ROW_W-1:0] w;
        w = '0;
        for (int c = 0; c < ROW_PIX; c++) w[c*PIX_W +: PIX_W] = img[r*ROW_PIX + c];
        return w;
    endfunction

    function automatic logic [ROW_W-1:0] ramp_word(input logic [7:0] b0);
        logic [ROW_W-1:0] w;
        w = '0;
        for (int c = 0; c < ROW_PIX; c++) w[c*PIX_W +: PIX_W] = b0 + 8'(c);
        return w;
    endfunction

    function automatic logic [7:0] pix_of(input int i, input int seed);
        if (seed == 0) return 8'((i / ROW_PIX) * 16 + (i % ROW_PIX));
        return 8'(i * seed + 3);
    endfunction

    // One clock: model predicts from pre-edge inputs, DUT checked 1 ns after the edge.
    task automatic step();
        bit ready;
        bit exp_valid;
        bit exp_err;
        int r;
        ready     = (cnt == FRAME_PIX);
        exp_valid = rd_req;
        exp_err   = 1'b0;
        if (rd_req) begin
            r = int'(rd_row);
            exp_err = !ready || frame_clr;
`ifndef REF_ROW_PAD_EN
            if (r >= NUM_ROWS) exp_err = 1'b1;
`endif
            if (r >= NUM_ROWS) r = NUM_ROWS - 1;
            exp_data = exp_err ? '0 : model_row(r);
        end
        if (frame_clr) begin
            cnt = 0;
        end else if (wr_valid && !ready) begin
            img[cnt] = wr_pixel;
            cnt++;
        end
        @(posedge clk);
        #1;
        check("wr_ready",    ROW_W'(wr_ready),    ROW_W'(cnt != FRAME_PIX));
        check("frame_ready", ROW_W'(frame_ready), ROW_W'(cnt == FRAME_PIX));
        check("rd_valid",    ROW_W'(rd_valid),    ROW_W'(exp_valid));
        check("rd_err",      ROW_W'(rd_err),      ROW_W'(exp_err));
        check("rd_data",     rd_data,             exp_data);
    endtask

    task automatic load_range(input int seed, input int from, input int to);
        for (int i = from; i < to; i++) begin
            wr_valid = 1'b1;
            wr_pixel = pix_of(i, seed);
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic read_row(input logic [7:0] r);
        rd_req = 1'b1;
        rd_row = r;
        step();
        rd_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"},    ROW_W'(wr_ready),    ROW_W'(1));
        check({tag, "_frame_ready"}, ROW_W'(frame_ready), ROW_W'(0));
        check({tag, "_rd_valid"},    ROW_W'(rd_valid),    ROW_W'(0));
        check({tag, "_rd_err"},      ROW_W'(rd_err),      ROW_W'(0));
        check({tag, "_rd_data"},     rd_data,             '0);
    endtask

    // Called 1 ns after an edge: reset is raised and checked between edges.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        cnt       = 0;
        exp_data  = '0;
        wr_valid  = 1'b0;
        rd_req    = 1'b0;
        frame_clr = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_pixel  = '0;
        frame_clr = 1'b0;
        rd_req    = 1'b0;
        rd_row    = '0;
        cnt       = 0;
        exp_data  = '0;

        tbl[0] = '{row: 8'd3,  exp_err: 1'b0, exp_b0: 8'h30};
        tbl[1] = '{row: 8'd0,  exp_err: 1'b0, exp_b0: 8'h00};
        tbl[2] = '{row: 8'd14, exp_err: 1'b0, exp_b0: 8'he0};
        tbl[3] = '{row: 8'd9,  exp_err: 1'b0, exp_b0: 8'h90};
`ifdef REF_ROW_PAD_EN
        tbl[4] = '{row: 8'd20,  exp_err: 1'b0, exp_b0: 8'he0};
        tbl[5] = '{row: 8'd255, exp_err: 1'b0, exp_b0: 8'he0};
`else
        tbl[4] = '{row: 8'd20,  exp_err: 1'b1, exp_b0: 8'h00};
        tbl[5] = '{row: 8'd255, exp_err: 1'b1, exp_b0: 8'h00};
`endif

        #12;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full ramp frame, then table-driven reads.
        load_range(0, 0, FRAME_PIX);
        check("ready_after_225", ROW_W'(frame_ready), ROW_W'(1));
        for (int k = 0; k < 6; k++) begin
            read_row(tbl[k].row);
            check("tbl_err",  ROW_W'(rd_err), ROW_W'(tbl[k].exp_err));
            check("tbl_data", rd_data, tbl[k].exp_err ? '0 : ramp_word(tbl[k].exp_b0));
            step();
        end

        // Back-to-back reads, then a hold cycle.
        rd_req = 1'b1;
        rd_row = 8'd0;  step(); check("b2b_row0",  ROW_W'(rd_data[7:0]), ROW_W'(8'h00));
        rd_row = 8'd14; step(); check("b2b_row14", ROW_W'(rd_data[7:0]), ROW_W'(8'he0));
        rd_row = 8'd7;  step(); check("b2b_row7",  ROW_W'(rd_data[7:0]), ROW_W'(8'h70));
        rd_req = 1'b0;
        step();
        check("hold_data", rd_data, ramp_word(8'h70));

        // Clear from READY with a pixel present, then a read during LOAD.
        frame_clr = 1'b1; wr_valid = 1'b1; wr_pixel = 8'h5a;
        step();
        frame_clr = 1'b0;
        load_range(2, 0, 40);
        rd_req = 1'b1; rd_row = 8'd5;
        load_range(2, 40, 41);
        rd_req = 1'b0;
        check("load_rd_err", ROW_W'(rd_err), ROW_W'(1));
        load_range(2, 41, 100);

        // Clear with a pixel in the same cycle after 100 pixels.
        frame_clr = 1'b1; wr_valid = 1'b1; wr_pixel = 8'haa;
        step();
        frame_clr = 1'b0; wr_valid = 1'b0;
        check("clr_wr_ready",    ROW_W'(wr_ready),    ROW_W'(1));
        check("clr_frame_ready", ROW_W'(frame_ready), ROW_W'(0));
        load_range(3, 0, FRAME_PIX);
        read_row(8'd0);
        check("clr_row0_col0", ROW_W'(rd_data[7:0]), ROW_W'(8'd3));
        read_row(8'd14);

        // Async reset mid-load, then mid-read.
        frame_clr = 1'b1; step(); frame_clr = 1'b0;
        load_range(5, 0, 60);
        async_reset("rst_load");
        load_range(0, 0, FRAME_PIX);
        read_row(8'd3);
        check("post_rst_row3", rd_data, ramp_word(8'h30));
        rd_req = 1'b1;
        async_reset("rst_read");
        load_range(7, 0, FRAME_PIX);
        read_row(8'd9);
        read_row(8'd2);

        // Randomized traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            wr_valid  = ($urandom % 4) != 0;
            wr_pixel  = 8'($urandom);
            frame_clr = ($urandom % 500) == 0;
            rd_req    = ($urandom % 2) != 0;
            rd_row    = 8'($urandom_range(0, 20));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
